// File: rtl/wb_mem_responder_if.sv
// Wishbone classic-cycle bus between one initiator and the memory responder.
// Parameters must match those of the responder instance that uses it.
interface wb_mem_responder_if #(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8
);
    logic [addr_width-1:0]   wb_adr;
    logic [data_width-1:0]   wb_datwr;
    logic [data_width-1:0]   wb_datrd;
    logic                    wb_we;
    logic                    wb_stb;
    logic                    wb_ack;
    logic                    wb_cyc;
    logic [strobe_width-1:0] wb_sel;

    modport master (
        output wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
        input  wb_datrd, wb_ack
    );

    modport slave (
        input  wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
        output wb_datrd, wb_ack
    );
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone classic-cycle memory responder with byte-lane writes and a
// configurable number of wait states before the single-cycle acknowledge.
module wb_mem_responder #(
    parameter int    addr_width   = 32,
    parameter int    data_width   = 32,
    parameter int    strobe_width = data_width / 8,
    parameter int    depth        = 1024,
    parameter int    wait_cycles  = 0,
    parameter string init_file    = ""
) (
    input  logic              clock,
    input  logic              reset,
    wb_mem_responder_if.slave bus
);
    localparam int lsb_w     = (strobe_width > 1) ? $clog2(strobe_width) : 0;
    localparam int idx_w     = (depth > 1) ? $clog2(depth) : 1;
    localparam int wait_init = (wait_cycles > 0) ? wait_cycles - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    logic [data_width-1:0] mem [depth];

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [idx_w-1:0]        idx_q, idx_d;
    logic                    we_q, we_d;
    logic [data_width-1:0]   dat_q, dat_d;
    logic [strobe_width-1:0] sel_q, sel_d;
    logic                    ack_q, ack_d;
    logic [data_width-1:0]   datrd_q, datrd_d;

    logic                    req;
    logic                    go_ack;
    logic [idx_w-1:0]        req_idx;
    logic                    req_we;
    logic [data_width-1:0]   req_dat;
    logic [strobe_width-1:0] req_sel;
    logic                    unused_adr;

    // Byte-offset and out-of-range address bits are deliberately ignored.
    assign unused_adr = ^bus.wb_adr;

    assign req = bus.wb_cyc && bus.wb_stb;

    // With zero wait states the access happens on the sampling edge itself,
    // so the live bus values stand in for the not-yet-latched request.
    always_comb begin
        req_idx = idx_q;
        req_we  = we_q;
        req_dat = dat_q;
        req_sel = sel_q;
        if (state_q == ST_IDLE) begin
            req_idx = bus.wb_adr[lsb_w +: idx_w];
            req_we  = bus.wb_we;
            req_dat = bus.wb_datwr;
            req_sel = bus.wb_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        datrd_d = datrd_q;
        go_ack  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d = req_idx;
                    we_d  = req_we;
                    dat_d = req_dat;
                    sel_d = req_sel;
                    if (wait_cycles > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(wait_init);
                    end else begin
                        state_d = ST_ACK;
                        go_ack  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    go_ack  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (go_ack && !req_we) begin
            datrd_d = mem[req_idx];
        end
        ack_d = (state_d == ST_ACK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            datrd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            datrd_q <= datrd_d;
        end
    end

    // Memory survives reset; a write on an edge held in reset never commits.
    always_ff @(posedge clock) begin
        if (reset && go_ack && req_we) begin
            for (int i = 0; i < strobe_width; i++) begin
                if (req_sel[i]) begin
                    mem[req_idx][8*i +: 8] <= req_dat[8*i +: 8];
                end
            end
        end
    end

    assign bus.wb_ack   = ack_q;
    assign bus.wb_datrd = datrd_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: one instance with no wait states, one with three,
// driven by directed and random transfers against a word-array reference model.
module tb_wb_mem_responder;
    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] datwr;
    logic        we;
    logic [3:0]  sel;
    logic        cyc0, stb0, cyc3, stb3;

    int tests_run;
    int tests_failed;

    bit [31:0] m0 [int];
    bit [31:0] m3 [int];
    int        wq0 [$];
    int        wq3 [$];

    wb_mem_responder_if #(.addr_width(32), .data_width(32)) bus0 ();
    wb_mem_responder_if #(.addr_width(32), .data_width(32)) bus3 ();

    assign bus0.wb_adr   = adr;
    assign bus0.wb_datwr = datwr;
    assign bus0.wb_we    = we;
    assign bus0.wb_sel   = sel;
    assign bus0.wb_cyc   = cyc0;
    assign bus0.wb_stb   = stb0;
    assign bus3.wb_adr   = adr;
    assign bus3.wb_datwr = datwr;
    assign bus3.wb_we    = we;
    assign bus3.wb_sel   = sel;
    assign bus3.wb_cyc   = cyc3;
    assign bus3.wb_stb   = stb3;

    wb_mem_responder #(.depth(1024), .wait_cycles(0)) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    wb_mem_responder #(.depth(1024), .wait_cycles(3)) dut3 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (s[l]) r[8*l +: 8] = nw[8*l +: 8];
        return r;
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] dat,
                               input logic [3:0] s);
        int i;
        i = idx_of(a);
        if (d == 0) begin
            if (!m0.exists(i)) begin m0[i] = '0; wq0.push_back(i); end
            m0[i] = merge(m0[i], dat, s);
        end else begin
            if (!m3.exists(i)) begin m3[i] = '0; wq3.push_back(i); end
            m3[i] = merge(m3[i], dat, s);
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        int i;
        i = idx_of(a);
        if (d == 0) return m0.exists(i) ? m0[i] : 32'hxxxx_xxxx;
        return m3.exists(i) ? m3[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic ack_of(input int d);
        return (d == 0) ? bus0.wb_ack : bus3.wb_ack;
    endfunction

    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? bus0.wb_datrd : bus3.wb_datrd;
    endfunction

    // One complete transfer; lat counts edges between the sample edge and the ack edge.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dat,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        adr = a; datwr = dat; we = w; sel = s;
        cyc0 = (d == 0); stb0 = (d == 0);
        cyc3 = (d == 3); stb3 = (d == 3);
        @(posedge clk);
        lat = 99;
        rd  = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack_of(d)) begin
                lat = k;
                rd  = rd_of(d);
                break;
            end
            @(posedge clk);
        end
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        @(negedge clk);
        chk($sformatf("ack_pulse_d%0d", d), {31'd0, ack_of(d)}, 32'd0);
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat,
                            input logic [3:0] s);
        logic [31:0] rd;
        int          lat;
        xfer(d, 1'b1, a, dat, s, rd, lat);
        chk($sformatf("wr_lat_d%0d_%h", d, a), 32'(lat), 32'(d));
        model_write(d, a, dat, s);
    endtask

    task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] rd);
        int lat;
        xfer(d, 1'b0, a, '0, 4'h0, rd, lat);
        chk($sformatf("rd_lat_d%0d_%h", d, a), 32'(lat), 32'(d));
        chk($sformatf("rd_data_d%0d_%h", d, a), rd, model_read(d, a));
    endtask

    initial begin
        logic [31:0] rd;
        logic [11:0] ack_seen;
        int          ack_cnt;
        logic [31:0] a, dat;
        logic [3:0]  s;
        int          i;

        tests_run = 0;
        tests_failed = 0;
        adr = '0; datwr = '0; we = 1'b0; sel = '0;
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack0", {31'd0, bus0.wb_ack}, 32'd0);
        chk("rst_rd0", bus0.wb_datrd, 32'd0);
        chk("rst_ack3", {31'd0, bus3.wb_ack}, 32'd0);
        chk("rst_rd3", bus3.wb_datrd, 32'd0);
        rst_n = 1'b1;

        // Zero wait states: full write, byte lanes, wrap, empty select.
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
        do_read(0, 32'h10, rd);
        chk("t1_const", rd, 32'hDEADBEEF);
        do_write(0, 32'h20, 32'h11223344, 4'hF);
        do_write(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_read(0, 32'h20, rd);
        chk("t2_const", rd, 32'h11BB33DD);
        do_write(0, 32'h1000, 32'hCAFEF00D, 4'hF);
        do_read(0, 32'h0000, rd);
        chk("wrap_const", rd, 32'hCAFEF00D);
        do_read(0, 32'h0002, rd);
        chk("unaligned_const", rd, 32'hCAFEF00D);
        do_write(0, 32'h20, 32'h55555555, 4'h0);
        do_read(0, 32'h20, rd);
        chk("sel0_const", rd, 32'h11BB33DD);

        // Three wait states.
        do_write(3, 32'h10, 32'hDEADBEEF, 4'hF);
        do_read(3, 32'h10, rd);
        chk("t1w3_const", rd, 32'hDEADBEEF);
        do_write(3, 32'h20, 32'h11223344, 4'hF);
        do_write(3, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_read(3, 32'h20, rd);
        chk("t2w3_const", rd, 32'h11BB33DD);

        // Request held high: acks expected 3 and 8 edges after the first sample.
        @(negedge clk);
        adr = 32'h10; we = 1'b0; sel = 4'h0; cyc3 = 1'b1; stb3 = 1'b1;
        @(posedge clk);
        ack_seen = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ack_seen[c] = bus3.wb_ack;
            if (bus3.wb_ack) chk($sformatf("b2b_data_%0d", c), bus3.wb_datrd, model_read(3, 32'h10));
            if (c < 11) @(posedge clk);
        end
        cyc3 = 1'b0; stb3 = 1'b0;
        chk("b2b_ack_pattern", {20'd0, ack_seen}, 32'h108);
        repeat (3) @(negedge clk);

        // Abort during the wait states.
        do_write(3, 32'h40, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        adr = 32'h40; datwr = 32'h12345678; we = 1'b1; sel = 4'hF; cyc3 = 1'b1; stb3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc3 = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus3.wb_ack) ack_cnt++;
        end
        stb3 = 1'b0;
        chk("abort_no_ack", 32'(ack_cnt), 32'd0);
        do_read(3, 32'h40, rd);
        chk("abort_const", rd, 32'h0BADF00D);

        // Asynchronous reset between edges while the responder is waiting.
        @(negedge clk);
        adr = 32'h10; we = 1'b0; cyc3 = 1'b1; stb3 = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ack3", {31'd0, bus3.wb_ack}, 32'd0);
        chk("async_rd3", bus3.wb_datrd, 32'd0);
        chk("async_rd0", bus0.wb_datrd, 32'd0);
        cyc3 = 1'b0; stb3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus3.wb_ack) ack_cnt++;
        end
        chk("async_no_ack", 32'(ack_cnt), 32'd0);
        do_read(3, 32'h10, rd);
        chk("async_keep3", rd, 32'hDEADBEEF);
        do_read(0, 32'h10, rd);
        chk("async_keep0", rd, 32'hDEADBEEF);

        // Random traffic on both instances, addresses with random upper bits.
        for (int n = 0; n < 60; n++) begin
            int d;
            d = (n % 2 == 0) ? 0 : 3;
            if ($urandom_range(0, 1) == 1) begin
                if (d == 0) i = wq0[$urandom_range(0, wq0.size() - 1)];
                else        i = wq3[$urandom_range(0, wq3.size() - 1)];
                a = ($urandom() & 32'hFFFF_F003) | (32'(i) << 2);
                do_read(d, a, rd);
            end else begin
                a   = $urandom();
                dat = $urandom();
                s   = 4'($urandom_range(0, 15));
                if (d == 0 && !m0.exists(idx_of(a))) s = 4'hF;
                if (d == 3 && !m3.exists(idx_of(a))) s = 4'hF;
                do_write(d, a, dat, s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
